// File: rtl/queue_uart_tx_pkg.sv
// ============================================================================
// queue_uart_tx_pkg -- shared FSM encodings, parity modes and width helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package queue_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/queue_uart_tx_baud_tick_gen.sv
// ============================================================================
// baud_tick_gen -- per-bit cycle counter, tick in the last cycle of each bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module baud_tick_gen
    import queue_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              CW     = min1_clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   C_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/queue_uart_tx.sv
// ============================================================================
// queue_uart_tx -- UART transmitter that dequeues words from an upstream buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module queue_uart_tx
    import queue_uart_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable_i,
    input  logic             empty_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             deq_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int            IW         = min1_clog2(WIDTH);
    localparam logic [IW-1:0] C_IDX_LAST = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic             par_q,   par_d;
    logic             tx_q,    tx_d;
    logic             tick;
    logic             clr;
    logic             par_bit;

    // Parity is computed from the word as it is captured, so later shifting
    // of the data register does not disturb it.
    generate
        if (PARITY == PARITY_ODD) begin : g_par_odd
            assign par_bit = ~(^data_i);
        end else begin : g_par_even
            assign par_bit = ^data_i;
        end
    endgenerate

    assign deq_o  = (state_q == ST_IDLE) & enable_i & ~empty_i & rstn;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_STOP) & tick;
    assign tx_o   = tx_q;
    assign clr    = (state_d != state_q) | (state_q == ST_IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (clr),
        .tick_o (tick)
    );

    // tx_d is the line level of the state being entered, giving a registered line.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (deq_o) begin
                    state_d = ST_START;
                    shift_d = data_i;
                    par_d   = par_bit;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == C_IDX_LAST) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/queue_uart_tx.md
QUEUE_UART_TX -- requirements
Module: queue_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (matches the upstream ring buffer WIDTH).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit, legal range >= 2.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable_i  input  1  permits starting a new frame.
REQ-007 SHALL have port empty_i  input  1  upstream buffer empty flag.
REQ-008 SHALL have port data_i  input  WIDTH  upstream dequeue data, valid only in the cycle deq_o is high.
REQ-009 SHALL have port deq_o  output  1  dequeue strobe to the upstream buffer, one cycle per word.
REQ-010 SHALL have port tx_o  output  1  serial line, idle high.
REQ-011 SHALL have port busy_o  output  1  high while a frame is in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
REQ-014 deq_o SHALL be combinational: high iff state==IDLE & enable_i & ~empty_i & rstn.
REQ-015 data_i SHALL be captured into the shift register on the same edge where deq_o is high; the FSM moves IDLE->START on that edge.
REQ-016 tx_o SHALL be registered: low for exactly CLKS_PER_BIT cycles in START, starting the cycle after deq_o.
REQ-017 DATA SHALL emit WIDTH bits LSB first, each held CLKS_PER_BIT cycles.
REQ-018 PAR (entered only if PARITY!=0) SHALL emit one bit for CLKS_PER_BIT cycles: even -> XOR of the word; odd -> inverted XOR.
REQ-019 STOP SHALL hold tx_o high for CLKS_PER_BIT cycles, then return to IDLE; done_o SHALL pulse in the last STOP cycle.
REQ-020 The baud counter SHALL count 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT), reset to 0 on every state entry.
REQ-021 The bit index SHALL count 0..WIDTH-1, width $clog2(WIDTH) (min 1 bit); DATA exits after index WIDTH-1 completes.
REQ-022 busy_o SHALL be high in START, DATA, PAR and STOP; low in IDLE.
REQ-023 Frame length SHALL be (WIDTH+2+(PARITY!=0))*CLKS_PER_BIT cycles; the minimum deq_o spacing is frame length + 1.
REQ-024 enable_i deasserted mid-frame SHALL NOT abort the frame; it only blocks the next dequeue.
REQ-025 empty_i high in IDLE SHALL keep deq_o low and tx_o high indefinitely.
REQ-026 Changes on data_i or empty_i outside the deq_o cycle SHALL NOT affect the frame in flight.

Reset
REQ-027 On rstn low at a clk edge: state IDLE, tx_o 1, busy_o 0, done_o 0, counters 0, shift register 0.
REQ-028 deq_o SHALL be forced low while rstn is low.
REQ-029 Reset mid-frame SHALL abort the frame, with tx_o high on the next cycle; the dequeued word is discarded.

Structure
REQ-030 A shared package SHALL hold the FSM state encodings and the PARITY mode constants (NONE, EVEN, ODD).
REQ-031 The baud counter SHALL be a sub-module baud_tick_gen (params CLKS_PER_BIT; ports clk, rstn, clr_i, tick_o).

Verification
REQ-032 WIDTH=8, CLKS_PER_BIT=4, PARITY=0; one word 0xA5 queued, enable_i=1:
 - deq_o high for 1 cycle;
 - tx_o sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total);
 - done_o pulses at cycle 40.
REQ-033 PARITY=1, word 0x01:
 - parity bit 1;
 - PARITY=2 with the same word -> parity bit 0;
 - frame 44 cycles.
REQ-034 Three words queued, enable_i=1:
 - deq_o pulses exactly 41 cycles apart;
 - tx_o stays high for exactly 1 cycle between frames.
REQ-035 Drop enable_i in mid-DATA:
 - the frame completes;
 - no further deq_o until enable_i returns.
REQ-036 Pull rstn low in DATA bit 3:
 - next cycle tx_o=1, busy_o=0, state IDLE;
 - the next frame after release is correct and carries the next queued word.
REQ-037 empty_i held 1 for 100 cycles: deq_o=0, tx_o=1, busy_o=0 throughout.
